affine_ctrl: RTL and testbench
==============================

AFFINE_CTRL -- requirements
Module: affine_ctrl

Interface
REQ-001 Parameter P, default 5: program counter width; program memory holds 2**P words.
REQ-002 Parameter W_INST, default 28: instruction width, taken from the affine package (OP 6, I2 8, I1 8, RD 3, RS 3; MSB to LSB in that order).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 instr  in  W_INST  instruction word, combinationally addressed by pc by the external program ROM.
REQ-006 hs  in  1  asynchronous external handshake switch (SW8).
REQ-007 pc  out  P  current program counter, driven to the ROM.
REQ-008 ctrl  out  6  registered ALU control, tOP packing {frac_c, wdual, mul_a_sel[1:0], add_b_sel[1:0]}.
REQ-009 rd, rs  out  3 each  registered register addresses.
REQ-010 imm1, imm2  out  8 each  registered immediates I1, I2.
REQ-011 reg_we  out  1  registered register-file write enable.
REQ-012 busy  out  1  high while the state is WAIT.
REQ-013 halted  out  1  high while the state is HALT.

Function
REQ-014 Decode: if OP[3:2] != 2'b11, the instruction SHALL be an ALU op.
REQ-015 Decode: if OP[3:2] == 2'b11, the instruction SHALL be a special op selected by OP[1:0]: 00 WAITH, 01 WAITL, 10 JMP, 11 HALT; OP[5:4] are ignored.
REQ-016 hs SHALL pass through a 2-flop synchroniser; hs_s denotes the second flop; all handshake decisions use hs_s only.
REQ-017 FSM states SHALL be RUN, WAIT, HALT.
REQ-018 RUN + ALU op: next edge pc<=pc+1; ctrl<=OP; rd, rs, imm1, imm2 <= fields; reg_we<=1.
REQ-019 RUN + JMP: next edge pc<=I1[P-1:0] (upper bits discarded); reg_we<=0; ctrl<=0.
REQ-020 RUN + WAITH with hs_s==1, or WAITL with hs_s==0: next edge pc<=pc+1, reg_we<=0, no stall.
REQ-021 RUN + WAITH with hs_s==0, or WAITL with hs_s==1: state<=WAIT, pc held, reg_we<=0.
REQ-022 WAIT: each edge, the instruction at pc (still the wait op) SHALL be re-evaluated. On condition met: pc<=pc+1, state<=RUN. Otherwise hold with reg_we=0.
REQ-023 RUN + HALT: state<=HALT; pc held; reg_we<=0. HALT SHALL be left only by reset.
REQ-024 Output latency: the decoded ALU fields SHALL appear on the outputs exactly one clock after the instruction is presented at pc.
REQ-025 Any non-ALU cycle SHALL drive reg_we=0 and ctrl=0; rd, rs, imm1, imm2 retain their previous values.
REQ-026 pc SHALL wrap from 2**P-1 to 0 on increment, with no flag.
REQ-027 busy and halted SHALL be combinational decodes of the state register.

Reset
REQ-028 While reset is high: pc=0, ctrl=0, rd=rs=0, imm1=imm2=0, reg_we=0, state=RUN, both synchroniser flops=0; these SHALL apply immediately, without waiting for clk.
REQ-029 Reset asserted in WAIT or HALT SHALL return the block to RUN with pc=0; after release, execution restarts from word 0 on the first edge.

Verification
REQ-030 Reset, then ROM[0]=ALU op 6'b100101, rd=2, rs=5, I1=8'h3C, I2=8'hA1 -> after edge 1: pc=1, ctrl=6'b100101, rd=2, rs=5, imm1=3C, imm2=A1, reg_we=1.
REQ-031 ROM[1]=WAITH with hs=0 -> busy=1, pc=1, reg_we=0 held indefinitely. Raise hs -> pc=2 exactly 3 edges later (2 sync + 1), busy=0.
REQ-032 ROM[2]=WAITL with hs still 1 -> stalls. Drop hs -> pc=3 after 3 edges. ROM[3]=WAITL with hs=0 already -> passes in 1 edge, no busy.
REQ-033 JMP with I1=8'hE7, P=5 -> pc=5'h07 next edge, reg_we=0. Separately, ALU op at pc=31 -> pc=0.
REQ-034 HALT at pc=4 -> halted=1, pc=4 stable for 20 edges with hs toggling. Assert reset between edges -> pc=0 and halted=0 immediately; execution resumes from 0.
REQ-035 Pulse hs high for a single cycle shorter than a clock period, away from edges, during WAITH -> no advance is required; a hs held for 2 or more edges SHALL advance.

Source files
------------

// File: rtl/affine_ctrl.sv
// Affine-processor sequencer: fetches instruction words from an external ROM
// addressed by pc, decodes ALU and special (wait/jump/halt) ops, and presents
// registered ALU control and operand fields one clock after fetch.

package affine_pkg;

  // Instruction field widths, MSB to LSB: OP, I2, I1, RD, RS.
  localparam int unsigned OP_W   = 6;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned INST_W = OP_W + 2 * IMM_W + 2 * REG_W;

  // Bit positions of each field inside the instruction word.
  localparam int unsigned RS_LSB = 0;
  localparam int unsigned RD_LSB = RS_LSB + REG_W;
  localparam int unsigned I1_LSB = RD_LSB + REG_W;
  localparam int unsigned I2_LSB = I1_LSB + IMM_W;
  localparam int unsigned OP_LSB = I2_LSB + IMM_W;

  // Special operations, selected by OP[1:0] when OP[3:2] == 2'b11.
  typedef enum logic [1:0] {
    SP_WAITH = 2'b00,
    SP_WAITL = 2'b01,
    SP_JMP   = 2'b10,
    SP_HALT  = 2'b11
  } spec_op_t;

endpackage

module affine_ctrl #(
  parameter int P      = 5,
  parameter int W_INST = affine_pkg::INST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W_INST-1:0] instr,
  input  logic              hs,
  output logic [P-1:0]      pc,
  output logic [5:0]        ctrl,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [7:0]        imm1,
  output logic [7:0]        imm2,
  output logic              reg_we,
  output logic              busy,
  output logic              halted
);

  import affine_pkg::*;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [P-1:0] PC_ONE = 1;

  // Instruction fields
  logic [OP_W-1:0]  op;
  logic [IMM_W-1:0] f_i2;
  logic [IMM_W-1:0] f_i1;
  logic [REG_W-1:0] f_rd;
  logic [REG_W-1:0] f_rs;

  assign op   = instr[OP_LSB +: OP_W];
  assign f_i2 = instr[I2_LSB +: IMM_W];
  assign f_i1 = instr[I1_LSB +: IMM_W];
  assign f_rd = instr[RD_LSB +: REG_W];
  assign f_rs = instr[RS_LSB +: REG_W];

  logic     is_special;
  spec_op_t sp_op;
  logic     wait_ok;

  // Handshake synchroniser
  logic hs_m;
  logic hs_s;

  // Registered state and its next values
  state_t       state, state_n;
  logic [P-1:0] pc_n;
  logic [P-1:0] pc_inc;
  logic [5:0]   ctrl_n;
  logic [2:0]   rd_n, rs_n;
  logic [7:0]   imm1_n, imm2_n;
  logic         reg_we_n;

  assign is_special = (op[3:2] == 2'b11);
  assign sp_op      = spec_op_t'(op[1:0]);
  // WAITH proceeds on hs_s high, WAITL on hs_s low; OP[0] picks the polarity.
  assign wait_ok    = op[0] ? ~hs_s : hs_s;
  assign pc_inc     = pc + PC_ONE;

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_m <= 1'b0;
      hs_s <= 1'b0;
    end else begin
      hs_m <= hs;
      hs_s <= hs_m;
    end
  end

  // State, program counter and registered decode outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      pc     <= '0;
      ctrl   <= '0;
      rd     <= '0;
      rs     <= '0;
      imm1   <= '0;
      imm2   <= '0;
      reg_we <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ctrl   <= ctrl_n;
      rd     <= rd_n;
      rs     <= rs_n;
      imm1   <= imm1_n;
      imm2   <= imm2_n;
      reg_we <= reg_we_n;
    end
  end

  // Next-state decode; non-ALU cycles clear ctrl/reg_we and keep operand fields.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ctrl_n   = '0;
    rd_n     = rd;
    rs_n     = rs;
    imm1_n   = imm1;
    imm2_n   = imm2;
    reg_we_n = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (!is_special) begin
          pc_n     = pc_inc;
          ctrl_n   = op;
          rd_n     = f_rd;
          rs_n     = f_rs;
          imm1_n   = f_i1;
          imm2_n   = f_i2;
          reg_we_n = 1'b1;
        end else begin
          unique case (sp_op)
            SP_WAITH, SP_WAITL: begin
              if (wait_ok) pc_n = pc_inc;
              else         state_n = ST_WAIT;
            end
            SP_JMP:  pc_n    = P'(f_i1);
            SP_HALT: state_n = ST_HALT;
            default: state_n = ST_RUN;
          endcase
        end
      end

      ST_WAIT: begin
        if (wait_ok) begin
          pc_n    = pc_inc;
          state_n = ST_RUN;
        end
      end

      ST_HALT: state_n = ST_HALT;

      default: state_n = ST_RUN;
    endcase
  end

  assign busy   = (state == ST_WAIT);
  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_affine_ctrl.sv
// Directed bench for affine_ctrl: ROM model indexed by pc, hand-computed
// expectations for ALU decode, handshake waits, jump, wrap, halt and reset.

module tb_affine_ctrl;

  localparam int P = 5;

  logic        clk;
  logic        reset;
  logic [27:0] instr;
  logic        hs;
  logic [4:0]  pc;
  logic [5:0]  ctrl;
  logic [2:0]  rd, rs;
  logic [7:0]  imm1, imm2;
  logic        reg_we, busy, halted;

  logic [27:0] rom [0:31];

  int n_tests = 0;
  int n_fail  = 0;

  assign instr = rom[pc];

  affine_ctrl #(.P(P), .W_INST(28)) dut (
    .clk    (clk),
    .reset  (reset),
    .instr  (instr),
    .hs     (hs),
    .pc     (pc),
    .ctrl   (ctrl),
    .rd     (rd),
    .rs     (rs),
    .imm1   (imm1),
    .imm2   (imm2),
    .reg_we (reg_we),
    .busy   (busy),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] mk(input logic [5:0] op, input logic [7:0] i2,
                                     input logic [7:0] i1, input logic [2:0] r_d,
                                     input logic [2:0] r_s);
    return {op, i2, i1, r_d, r_s};
  endfunction

  localparam logic [5:0] OP_WAITH = 6'b001100;
  localparam logic [5:0] OP_WAITL = 6'b001101;
  localparam logic [5:0] OP_JMP   = 6'b001110;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hs    = 1'b0;
    tick();
    tick();
    n_tests++; if (pc !== 5'd0)   begin n_fail++; $display("FAIL reset_pc got %0d want 0", pc); end
    n_tests++; if (ctrl !== 6'd0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0", ctrl); end
    n_tests++; if ({rd, rs, imm1, imm2} !== 22'd0) begin n_fail++; $display("FAIL reset_fields got %h want 0", {rd, rs, imm1, imm2}); end
    n_tests++; if ({reg_we, busy, halted} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {reg_we, busy, halted}); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    tick();
    n_tests++; if (pc !== 5'd1) begin n_fail++; $display("FAIL alu_pc got %0d want 1", pc); end
    n_tests++; if (ctrl !== 6'b100101) begin n_fail++; $display("FAIL alu_ctrl got %b want 100101", ctrl); end
    n_tests++; if ({rd, rs} !== {3'd2, 3'd5}) begin n_fail++; $display("FAIL alu_regs got rd=%0d rs=%0d want 2 5", rd, rs); end
    n_tests++; if ({imm1, imm2} !== 16'h3CA1) begin n_fail++; $display("FAIL alu_imm got %h %h want 3c a1", imm1, imm2); end
    n_tests++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL alu_we got %b want 1", reg_we); end
  endtask

  task automatic test_waith();
    tick();
    n_tests++; if ({busy, pc, reg_we, ctrl} !== {1'b1, 5'd1, 1'b0, 6'd0}) begin n_fail++; $display("FAIL waith_enter got busy=%b pc=%0d we=%b ctrl=%b want 1 1 0 0", busy, pc, reg_we, ctrl); end
    n_tests++; if ({rd, imm2} !== {3'd2, 8'hA1}) begin n_fail++; $display("FAIL waith_retain got rd=%0d imm2=%h want 2 a1", rd, imm2); end
    repeat (10) tick();
    n_tests++; if ({busy, pc, reg_we} !== {1'b1, 5'd1, 1'b0}) begin n_fail++; $display("FAIL waith_hold got busy=%b pc=%0d we=%b want 1 1 0", busy, pc, reg_we); end
    hs = 1'b1;
    tick();
    tick();
    n_tests++; if ({busy, pc} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL waith_sync got busy=%b pc=%0d want 1 1", busy, pc); end
    tick();
    n_tests++; if ({busy, pc} !== {1'b0, 5'd2}) begin n_fail++; $display("FAIL waith_release got busy=%b pc=%0d want 0 2", busy, pc); end
  endtask

  task automatic test_waitl();
    tick();
    n_tests++; if ({busy, pc} !== {1'b1, 5'd2}) begin n_fail++; $display("FAIL waitl_enter got busy=%b pc=%0d want 1 2", busy, pc); end
    hs = 1'b0;
    tick();
    tick();
    n_tests++; if ({busy, pc} !== {1'b1, 5'd2}) begin n_fail++; $display("FAIL waitl_sync got busy=%b pc=%0d want 1 2", busy, pc); end
    tick();
    n_tests++; if ({busy, pc} !== {1'b0, 5'd3}) begin n_fail++; $display("FAIL waitl_release got busy=%b pc=%0d want 0 3", busy, pc); end
    tick();
    n_tests++; if ({busy, pc, reg_we} !== {1'b0, 5'd4, 1'b0}) begin n_fail++; $display("FAIL waitl_pass got busy=%b pc=%0d we=%b want 0 4 0", busy, pc, reg_we); end
  endtask

  task automatic test_halt();
    logic stable;
    tick();
    n_tests++; if ({halted, pc, reg_we, ctrl} !== {1'b1, 5'd4, 1'b0, 6'd0}) begin n_fail++; $display("FAIL halt_enter got h=%b pc=%0d we=%b ctrl=%b want 1 4 0 0", halted, pc, reg_we, ctrl); end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hs = ~hs;
      tick();
      if ({halted, pc, reg_we, busy} !== {1'b1, 5'd4, 1'b0, 1'b0}) stable = 1'b0;
    end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL halt_stable got %b want 1 (pc=%0d h=%b)", stable, pc, halted); end
    #3 reset = 1'b1;
    #1;
    n_tests++; if ({halted, pc, ctrl, imm1} !== {1'b0, 5'd0, 6'd0, 8'd0}) begin n_fail++; $display("FAIL halt_async_reset got h=%b pc=%0d ctrl=%b imm1=%h want 0 0 0 0", halted, pc, ctrl, imm1); end
    hs = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    n_tests++; if ({pc, ctrl, reg_we} !== {5'd1, 6'b100101, 1'b1}) begin n_fail++; $display("FAIL halt_restart got pc=%0d ctrl=%b we=%b want 1 100101 1", pc, ctrl, reg_we); end
  endtask

  task automatic test_jmp_wrap();
    reset = 1'b1;
    hs    = 1'b0;
    rom[0]  = mk(OP_JMP, 8'h00, 8'hE7, 3'd0, 3'd0);
    rom[7]  = mk(OP_JMP, 8'h00, 8'h1F, 3'd0, 3'd0);
    rom[31] = mk(6'b000010, 8'hAA, 8'h55, 3'd7, 3'd1);
    tick();
    reset = 1'b0;
    tick();
    n_tests++; if ({pc, reg_we, ctrl} !== {5'h07, 1'b0, 6'd0}) begin n_fail++; $display("FAIL jmp_e7 got pc=%h we=%b ctrl=%b want 07 0 0", pc, reg_we, ctrl); end
    tick();
    n_tests++; if (pc !== 5'd31) begin n_fail++; $display("FAIL jmp_1f got pc=%0d want 31", pc); end
    tick();
    n_tests++; if ({pc, ctrl, rd, rs, reg_we} !== {5'd0, 6'b000010, 3'd7, 3'd1, 1'b1}) begin n_fail++; $display("FAIL wrap_alu got pc=%0d ctrl=%b rd=%0d rs=%0d we=%b want 0 000010 7 1 1", pc, ctrl, rd, rs, reg_we); end
    tick();
    n_tests++; if ({pc, ctrl, reg_we} !== {5'd7, 6'd0, 1'b0}) begin n_fail++; $display("FAIL jmp_after_alu got pc=%0d ctrl=%b we=%b want 7 0 0", pc, ctrl, reg_we); end
    n_tests++; if ({rd, imm1, imm2} !== {3'd7, 8'h55, 8'hAA}) begin n_fail++; $display("FAIL jmp_retain got rd=%0d imm1=%h imm2=%h want 7 55 aa", rd, imm1, imm2); end
  endtask

  task automatic test_pulse();
    reset = 1'b1;
    hs    = 1'b0;
    rom[0] = mk(OP_WAITH, 8'h00, 8'h00, 3'd0, 3'd0);
    rom[1] = mk(6'b010011, 8'h12, 8'h34, 3'd3, 3'd4);
    tick();
    reset = 1'b0;
    tick();
    n_tests++; if ({busy, pc} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL pulse_enter got busy=%b pc=%0d want 1 0", busy, pc); end
    #2 hs = 1'b1;
    #3 hs = 1'b0;
    repeat (4) tick();
    n_tests++; if ({busy, pc} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL pulse_ignored got busy=%b pc=%0d want 1 0", busy, pc); end
    hs = 1'b1;
    repeat (3) tick();
    n_tests++; if ({busy, pc} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL pulse_held got busy=%b pc=%0d want 0 1", busy, pc); end
    tick();
    n_tests++; if ({pc, ctrl, rd, rs, imm1, imm2} !== {5'd2, 6'b010011, 3'd3, 3'd4, 8'h34, 8'h12}) begin n_fail++; $display("FAIL back_to_back_alu got pc=%0d ctrl=%b rd=%0d rs=%0d i1=%h i2=%h want 2 010011 3 4 34 12", pc, ctrl, rd, rs, imm1, imm2); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = mk(6'b000000, 8'h00, 8'h00, 3'd0, 3'd0);
    rom[0] = mk(6'b100101, 8'hA1, 8'h3C, 3'd2, 3'd5);
    rom[1] = mk(OP_WAITH, 8'h00, 8'h00, 3'd0, 3'd0);
    rom[2] = mk(OP_WAITL, 8'h00, 8'h00, 3'd0, 3'd0);
    rom[3] = mk(OP_WAITL, 8'h00, 8'h00, 3'd0, 3'd0);
    rom[4] = mk(OP_HALT,  8'h00, 8'h00, 3'd0, 3'd0);
    reset = 1'b1;
    hs    = 1'b0;

    test_reset();
    test_alu();
    test_waith();
    test_waitl();
    test_halt();
    test_jmp_wrap();
    test_pulse();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
